// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control unit: steps each instruction through
// START/FETCH/DECODE/EXEC/MEM/WB and traps on an illegal opcode or a memory timeout.
// Ports:
//   clk, arst_n              clock, asynchronous active-low reset
//   opcode[6:0]              instr[6:0] from the instruction register
//   imem_ready, dmem_ready   memory completion strobes
//   imem_req, dmem_req       memory request levels (held until the matching ready)
//   dmem_we                  data request is a store
//   ir_write                 load the instruction register
//   pc_write, pc_sel[1:0]    PC update strobe and source (00 PC+4, 01 branch, 10 hold)
//   reg_write                register-file write enable
//   alu_src_imm, alu_op[1:0] ALU operand-B select and operation class
//   wb_sel                   writeback source (0 ALU, 1 memory)
//   illegal                  sticky trap flag
//   state_dbg[2:0]           current state encoding
// Outputs are decoded combinationally from the registered state/class (and the
// ready inputs), so an asynchronous reset drops every strobe immediately.
module multicycle_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic [6:0] opcode,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_sel,
  output logic       reg_write,
  output logic       alu_src_imm,
  output logic [1:0] alu_op,
  output logic       wb_sel,
  output logic       illegal,
  output logic [2:0] state_dbg
);

  localparam int unsigned CNT_W      = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam bit          TIMEOUT_EN = (MEM_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] PC_4      = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_HOLD   = 2'b10;

  typedef enum logic [2:0] {
    ST_START  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH
  } cls_t;

  state_t           state_q, state_d;
  cls_t             cls_q, cls_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             waiting;
  logic             expired;

  // State, instruction class and wait-counter registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= ST_START;
      cls_q      <= CL_R;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign waiting   = ((state_q == ST_FETCH) && !imem_ready) ||
                     ((state_q == ST_MEM)   && !dmem_ready);
  // Only consulted when ready is low: a ready in the expiry cycle wins.
  assign expired   = TIMEOUT_EN && (wait_cnt_q == CNT_LAST);
  assign state_dbg = state_q;

  // Next-state, class capture, wait counter and output decode
  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    wait_cnt_d  = wait_cnt_q;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_sel      = PC_HOLD;
    reg_write   = 1'b0;
    alu_src_imm = 1'b0;
    alu_op      = 2'b00;
    wb_sel      = 1'b0;
    illegal     = 1'b0;

    case (state_q)
      ST_START: state_d = ST_FETCH;

      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (expired) begin
          state_d = ST_TRAP;
        end
      end

      ST_DECODE: begin
        state_d = ST_EXEC;
        case (opcode)
          OP_R:      cls_d = CL_R;
          OP_I:      cls_d = CL_I;
          OP_LOAD:   cls_d = CL_LOAD;
          OP_STORE:  cls_d = CL_STORE;
          OP_BRANCH: cls_d = CL_BRANCH;
          default:   state_d = ST_TRAP;
        endcase
      end

      ST_EXEC: begin
        case (cls_q)
          CL_R: begin
            alu_op  = 2'b10;
            state_d = ST_WB;
          end
          CL_I: begin
            alu_op      = 2'b11;
            alu_src_imm = 1'b1;
            state_d     = ST_WB;
          end
          CL_LOAD, CL_STORE: begin
            alu_src_imm = 1'b1;
            state_d     = ST_MEM;
          end
          CL_BRANCH: begin
            alu_op   = 2'b01;
            pc_write = 1'b1;
            pc_sel   = PC_BRANCH;
            state_d  = ST_FETCH;
          end
          default: state_d = ST_TRAP;
        endcase
      end

      ST_MEM: begin
        // Address operands held stable for the whole access
        dmem_req    = 1'b1;
        dmem_we     = (cls_q == CL_STORE);
        alu_src_imm = 1'b1;
        if (dmem_ready) begin
          if (cls_q == CL_STORE) begin
            pc_write = 1'b1;
            pc_sel   = PC_4;
            state_d  = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (expired) begin
          state_d = ST_TRAP;
        end
      end

      ST_WB: begin
        reg_write = 1'b1;
        wb_sel    = (cls_q == CL_LOAD);
        pc_write  = 1'b1;
        pc_sel    = PC_4;
        state_d   = ST_FETCH;
      end

      ST_TRAP: illegal = 1'b1;

      default: state_d = ST_START;
    endcase

    // Clear on any state change (entry), count ready-low cycles, saturate
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (waiting && (wait_cnt_q != CNT_MAX)) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: each instruction is planned as a whole
// (opcode, fetch wait, memory wait) and expanded into an expected per-cycle trace.
module tb_multicycle_control_fsm;

  localparam int unsigned T = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_sel;
    logic       reg_write;
    logic       alu_src_imm;
    logic [1:0] alu_op;
    logic       wb_sel;
    logic       illegal;
  } vec_t;

  typedef struct packed {
    logic [6:0] opc;
    logic       ir;
    logic       dr;
    vec_t       e;
  } cyc_t;

  logic       clk;
  logic       arst_n;
  logic [6:0] opcode;
  logic       imem_ready;
  logic       dmem_ready;
  logic       imem_req;
  logic       dmem_req;
  logic       dmem_we;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_sel;
  logic       reg_write;
  logic       alu_src_imm;
  logic [1:0] alu_op;
  logic       wb_sel;
  logic       illegal;
  logic [2:0] state_dbg;

  cyc_t q[$];
  bit   trapped;
  int   trap_len;
  int   n_vec;
  int   n_err;

  multicycle_control_fsm #(.MEM_TIMEOUT(T)) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .opcode      (opcode),
    .imem_ready  (imem_ready),
    .dmem_ready  (dmem_ready),
    .imem_req    (imem_req),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_sel      (pc_sel),
    .reg_write   (reg_write),
    .alu_src_imm (alu_src_imm),
    .alu_op      (alu_op),
    .wb_sel      (wb_sel),
    .illegal     (illegal),
    .state_dbg   (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d vectors applied", n_vec);
    $fatal(1);
  end

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  // Quiet vector: every strobe low, PC held
  function automatic vec_t idle(input logic [2:0] st);
    vec_t v;
    v        = '0;
    v.st     = st;
    v.pc_sel = 2'b10;
    return v;
  endfunction

  function automatic vec_t wb(input logic is_load);
    vec_t v;
    v           = idle(3'd5);
    v.reg_write = 1'b1;
    v.wb_sel    = is_load;
    v.pc_write  = 1'b1;
    v.pc_sel    = 2'b00;
    return v;
  endfunction

  task automatic push(input vec_t e, input logic [6:0] opc, input logic ir, input logic dr);
    cyc_t c;
    c.opc = opc;
    c.ir  = ir;
    c.dr  = dr;
    c.e   = e;
    q.push_back(c);
  endtask

  task automatic trap_tail(input int n);
    vec_t v;
    v         = idle(3'd6);
    v.illegal = 1'b1;
    for (int k = 0; k < n; k++) push(v, rop(), rbit(), rbit());
    trapped = 1'b1;
  endtask

  // Memory wait: ready arrives after dly low cycles unless the timeout hits first
  task automatic wait_phase(input bit is_mem, input int dly, input vec_t base,
                            input vec_t done, output bit ok);
    ok = 1'b0;
    for (int k = 0; k <= dly; k++) begin
      if (k == dly) begin
        push(done, rop(), is_mem ? rbit() : 1'b1, is_mem ? 1'b1 : rbit());
        ok = 1'b1;
        return;
      end
      push(base, rop(), is_mem ? rbit() : 1'b0, is_mem ? 1'b0 : rbit());
      if (k == int'(T) - 1) return;
    end
  endtask

  // Expand one instruction into its expected cycle-by-cycle trace
  task automatic build(input logic [6:0] opc, input int di, input int dm);
    vec_t f, fr, v, m, mr;
    bit   ok;
    f          = idle(3'd1);
    f.imem_req = 1'b1;
    fr         = f;
    fr.ir_write = 1'b1;
    wait_phase(1'b0, di, f, fr, ok);
    if (!ok) begin
      trap_tail(trap_len);
      return;
    end
    push(idle(3'd2), opc, rbit(), rbit());
    v = idle(3'd3);
    case (opc)
      OP_R: begin
        v.alu_op = 2'b10;
        push(v, rop(), rbit(), rbit());
        push(wb(1'b0), rop(), rbit(), rbit());
      end
      OP_I: begin
        v.alu_op      = 2'b11;
        v.alu_src_imm = 1'b1;
        push(v, rop(), rbit(), rbit());
        push(wb(1'b0), rop(), rbit(), rbit());
      end
      OP_LOAD, OP_STORE: begin
        v.alu_src_imm = 1'b1;
        push(v, rop(), rbit(), rbit());
        m             = idle(3'd4);
        m.dmem_req    = 1'b1;
        m.alu_src_imm = 1'b1;
        m.dmem_we     = (opc == OP_STORE);
        mr            = m;
        if (opc == OP_STORE) begin
          mr.pc_write = 1'b1;
          mr.pc_sel   = 2'b00;
        end
        wait_phase(1'b1, dm, m, mr, ok);
        if (!ok) trap_tail(trap_len);
        else if (opc == OP_LOAD) push(wb(1'b1), rop(), rbit(), rbit());
      end
      OP_BRANCH: begin
        v.alu_op   = 2'b01;
        v.pc_write = 1'b1;
        v.pc_sel   = 2'b01;
        push(v, rop(), rbit(), rbit());
      end
      default: trap_tail(trap_len);
    endcase
  endtask

  task automatic check(input string name, input vec_t exp);
    vec_t act;
    act.st          = state_dbg;
    act.imem_req    = imem_req;
    act.dmem_req    = dmem_req;
    act.dmem_we     = dmem_we;
    act.ir_write    = ir_write;
    act.pc_write    = pc_write;
    act.pc_sel      = pc_sel;
    act.reg_write   = reg_write;
    act.alu_src_imm = alu_src_imm;
    act.alu_op      = alu_op;
    act.wb_sel      = wb_sel;
    act.illegal     = illegal;
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %b (state %0d) expected %b (state %0d)",
               name, $time, act, act.st, exp, exp.st);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Called just after a rising edge: pulse reset mid-cycle, see START, release
  task automatic do_reset();
    #2;
    arst_n = 1'b0;
    #1;
    check("async_reset", idle(3'd0));
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    check("start", idle(3'd0));
    @(posedge clk);
    #1;
    trapped = 1'b0;
  endtask

  // Replay the planned trace; abort_at >= 0 resets in that cycle instead
  task automatic run(input int abort_at);
    cyc_t c;
    int   idx;
    idx = 0;
    while (q.size() > 0) begin
      c          = q.pop_front();
      opcode     = c.opc;
      imem_ready = c.ir;
      dmem_ready = c.dr;
      if (idx == abort_at) begin
        q.delete();
        do_reset();
        return;
      end
      @(negedge clk);
      check("cycle", c.e);
      @(posedge clk);
      #1;
      idx++;
    end
  endtask

  initial begin
    logic [6:0] op;
    int         di;
    int         dm;
    int         abort;
    n_vec      = 0;
    n_err      = 0;
    trapped    = 1'b0;
    trap_len   = 3;
    arst_n     = 1'b0;
    opcode     = '0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // R-type, no wait: FETCH, DECODE, EXEC, WB
    build(OP_R, 0, 0);
    check_int("r_len", q.size(), 4);
    check_int("r_states", int'({q[0].e.st, q[1].e.st, q[2].e.st, q[3].e.st}), int'(12'o1235));
    check_int("r_wb_regwrite", int'(q[3].e.reg_write), 1);
    run(-1);

    build(OP_BRANCH, 0, 0);
    check_int("br_len", q.size(), 3);
    check_int("br_pc_sel", int'(q[2].e.pc_sel), 1);
    run(-1);

    build(OP_LOAD, 0, 3);
    check_int("ld_len", q.size(), 8);
    check_int("ld_wb_sel", int'(q[7].e.wb_sel), 1);
    run(-1);

    build(OP_STORE, 0, 0);
    check_int("st_len", q.size(), 4);
    run(-1);

    build(OP_I, 1, 0);
    run(-1);

    // Illegal opcode: trap held 20 cycles, reset clears the flag
    trap_len = 20;
    build(OP_BAD, 0, 0);
    check_int("bad_len", q.size(), 22);
    run(-1);
    trap_len = 3;
    do_reset();

    // Fetch timeout, then ready on the last allowed cycle
    build(OP_R, 10, 0);
    check_int("to_len", q.size(), 4 + 3);
    run(-1);
    do_reset();
    build(OP_R, 3, 0);
    check_int("late_len", q.size(), 7);
    run(-1);

    // Data timeout, then reset in the middle of a data access
    build(OP_STORE, 0, 4);
    run(-1);
    do_reset();
    build(OP_LOAD, 0, 5);
    run(4);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    op = OP_R;
        2, 3:    op = OP_I;
        4:       op = OP_LOAD;
        5:       op = OP_STORE;
        6, 7:    op = OP_BRANCH;
        8:       op = OP_LOAD;
        default: op = rop();
      endcase
      di = ($urandom_range(0, 9) == 0) ? int'($urandom_range(3, 6)) : int'($urandom_range(0, 2));
      dm = ($urandom_range(0, 9) == 0) ? int'($urandom_range(3, 6)) : int'($urandom_range(0, 2));
      build(op, di, dm);
      abort = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, q.size() - 1)) : -1;
      run(abort);
      if (trapped) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
